// File: rtl/bus_gen_arbiter_pkg.sv
// Shared definitions for the bus generator/arbiter: destination field width,
// broadcast ID and the two-state transaction FSM encoding.
package bus_gen_arbiter_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST = 8'hFF;

  typedef enum logic {
    IDLE    = 1'b0,
    DELIVER = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_gen_arbiter_rr_arbiter.sv
// Rotate-priority encoder: grants the first requester at or after ptr_i,
// wrapping past N-1 back to 0. Purely combinational.
module rr_arbiter
  import bus_gen_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_onehot_o,
  output logic [IW-1:0] gnt_idx_o
);

  int            cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  // Scan N candidates starting at the pointer; the first hit wins.
  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    found        = 1'b0;
    cand         = 0;
    cand_idx     = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      cand_idx = IW'(cand);
      if (en_i && !found && req_i[cand_idx]) begin
        found                  = 1'b1;
        gnt_onehot_o[cand_idx] = 1'b1;
        gnt_idx_o              = cand_idx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/bus_gen_arbiter.sv
// Shared-bus arbiter: pops one packet from a round-robin selected device,
// then delivers it unicast or broadcast on the next cycle.
module bus_gen_arbiter
  import bus_gen_arbiter_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);

  localparam int IW = idx_w(drvrs);

  state_t                          state_q;
  logic [IW-1:0]                   ptr_q;
  logic [IW-1:0]                   src_q;
  logic [pckg_sz-1:0]              pkt_q;
  logic [drvrs-1:0]                pop_q;
  logic [drvrs-1:0]                push_q;
  logic [drvrs-1:0][pckg_sz-1:0]   dpush_q;

  logic [drvrs-1:0]                gnt_onehot;
  logic [IW-1:0]                   gnt_idx;
  logic [ID_W-1:0]                 dest;
  logic                            dest_ok;
  logic [drvrs-1:0]                src_oh;
  logic [drvrs-1:0]                dest_oh;
  logic [drvrs-1:0]                push_d;

  rr_arbiter #(.N(drvrs), .IW(IW)) u_arb (
    .req_i        (pndng),
    .ptr_i        (ptr_q),
    .en_i         (state_q == IDLE),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx)
  );

  assign dest    = pkt_q[pckg_sz-1 -: ID_W];
  assign dest_ok = ({{(32-ID_W){1'b0}}, dest} < drvrs);
  assign src_oh  = {{(drvrs-1){1'b0}}, 1'b1} << src_q;
  assign dest_oh = dest_ok ? ({{(drvrs-1){1'b0}}, 1'b1} << dest) : '0;

  // Broadcast reaches everyone but the source; unknown IDs are dropped.
  always_comb begin
    if (dest == broadcast) begin
      push_d = ~src_oh;
    end else begin
      push_d = dest_oh;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      src_q   <= '0;
      pkt_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
      dpush_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          push_q <= '0;
          if (|pndng) begin
            pop_q   <= gnt_onehot;
            pkt_q   <= D_pop[gnt_idx];
            src_q   <= gnt_idx;
            state_q <= DELIVER;
          end else begin
            pop_q <= '0;
          end
        end
        DELIVER: begin
          pop_q  <= '0;
          push_q <= push_d;
          for (int j = 0; j < drvrs; j++) begin
            dpush_q[j] <= pkt_q;
          end
          ptr_q   <= (src_q == IW'(drvrs - 1)) ? '0 : src_q + IW'(1);
          state_q <= IDLE;
        end
        default: begin
          pop_q   <= '0;
          push_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pop    = pop_q;
  assign push   = push_q;
  assign D_push = dpush_q;

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Scoreboard bench for bus_gen_arbiter (6 devices, 32-bit packets): directed
// stimulus queues expected pops/pushes, an independent monitor checks them.
module tb_bus_gen_arbiter;

  localparam int N = 6;
  localparam int W = 32;

  typedef struct packed {
    logic [N-1:0] mask;
    logic [W-1:0] data;
  } push_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          pndng;
  logic [N-1:0][W-1:0]   D_pop;
  logic [N-1:0]          pop;
  logic [N-1:0]          push;
  logic [N-1:0][W-1:0]   D_push;

  logic [N-1:0] exp_pop_q[$];
  push_t        exp_push_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic         mon_rs;
  push_t        mon_e;

  bus_gen_arbiter #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_pop(input int dev);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pop[dev]) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_pop: no pop for device %0d within 20 cycles", dev);
    end
  endtask

  // Monitor: outputs are sampled just after each rising edge.
  always @(posedge clk) begin
    mon_rs = reset;
    #1;
    if (!mon_rs) begin
      if (pop != '0) begin
        if (exp_pop_q.size() == 0) chk("pop_unexpected", 64'(pop), 64'd0);
        else chk("pop_grant", 64'(pop), 64'(exp_pop_q.pop_front()));
      end
      if (push != '0) begin
        if (exp_push_q.size() == 0) begin
          chk("push_unexpected", 64'(push), 64'd0);
        end else begin
          mon_e = exp_push_q.pop_front();
          chk("push_mask", 64'(push), 64'(mon_e.mask));
          for (int j = 0; j < N; j++) chk("push_data", 64'(D_push[j]), 64'(mon_e.data));
        end
      end
      chk("pop_push_overlap", 64'(pop & push), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int d;
    reset = 1'b1;
    pndng = 6'h3F;
    for (int i = 0; i < N; i++) D_pop[i] = 32'hDEAD0000 | 32'(i);

    // 1. reset held with all devices pending
    repeat (5) begin
      @(negedge clk);
      chk("rst_pop", 64'(pop), 64'd0);
      chk("rst_push", 64'(push), 64'd0);
      for (int j = 0; j < N; j++) chk("rst_dpush", 64'(D_push[j]), 64'd0);
    end
    reset = 1'b0;
    pndng = '0;
    repeat (2) @(negedge clk);

    // 2. unicast 1 -> 3
    exp_pop_q.push_back(6'b000010);
    exp_push_q.push_back('{mask: 6'b001000, data: 32'h0300AB12});
    D_pop[1] = 32'h0300AB12;
    pndng[1] = 1'b1;
    wait_pop(1);
    pndng[1] = 1'b0;
    repeat (3) @(negedge clk);

    // 3. broadcast from 4
    exp_pop_q.push_back(6'b010000);
    exp_push_q.push_back('{mask: 6'b101111, data: 32'hFF000055});
    D_pop[4] = 32'hFF000055;
    pndng[4] = 1'b1;
    wait_pop(4);
    pndng[4] = 1'b0;
    repeat (3) @(negedge clk);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 4. all pending, fair rotation 0..5,0 two cycles apart
    for (int i = 0; i < N; i++) D_pop[i] = {8'((i + 1) % N), 24'(i * 24'h111)};
    for (int k = 0; k < 7; k++) begin
      d = k % N;
      exp_pop_q.push_back(6'b000001 << d);
      exp_push_q.push_back('{mask: 6'b000001 << ((d + 1) % N), data: D_pop[d]});
    end
    pndng = 6'h3F;
    prev = 0;
    for (int k = 0; k < 7; k++) begin
      wait_pop(k % N);
      if (k > 0) chk("rr_gap", 64'(cyc - prev), 64'd2);
      prev = cyc;
    end
    pndng = '0;
    repeat (3) @(negedge clk);

    // 5. invalid ID from 2 dropped, then 3 granted
    D_pop[2] = 32'h09000001;
    D_pop[3] = 32'h00C0FFEE;
    exp_pop_q.push_back(6'b000100);
    exp_pop_q.push_back(6'b001000);
    exp_push_q.push_back('{mask: 6'b000001, data: 32'h00C0FFEE});
    pndng = 6'b001100;
    wait_pop(2);
    pndng[2] = 1'b0;
    @(negedge clk);
    chk("invalid_no_push", 64'(push), 64'd0);
    wait_pop(3);
    pndng[3] = 1'b0;
    repeat (3) @(negedge clk);

    // 6. reset during DELIVER aborts; device 0 first afterwards
    D_pop[0] = 32'h01000077;
    D_pop[5] = 32'h05000055;
    exp_pop_q.push_back(6'b000001);
    pndng = 6'b000001;
    wait_pop(0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_push", 64'(push), 64'd0);
    @(negedge clk);
    chk("abort_push", 64'(push), 64'd0);
    exp_pop_q.push_back(6'b000001);
    exp_pop_q.push_back(6'b100000);
    exp_push_q.push_back('{mask: 6'b000010, data: 32'h01000077});
    exp_push_q.push_back('{mask: 6'b100000, data: 32'h05000055});
    reset = 1'b0;
    pndng = 6'b100001;
    wait_pop(0);
    pndng[0] = 1'b0;
    wait_pop(5);
    pndng[5] = 1'b0;
    repeat (4) @(negedge clk);

    chk("pop_queue_drained", 64'(exp_pop_q.size()), 64'd0);
    chk("push_queue_drained", 64'(exp_push_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
